// File: rtl/conv_sched_pkg.sv
// ============================================================================
// conv_sched_pkg - shared types and sizing helpers for the convolution scheduler
// Rev 1.0 - initial release
// ============================================================================
`default_nettype none

package conv_sched_pkg;

   typedef enum logic [2:0] {
      ST_IDLE    = 3'd0,
      ST_LOAD_K  = 3'd1,
      ST_LOAD_I  = 3'd2,
      ST_I_SHIFT = 3'd3,
      ST_COMPUTE = 3'd4
   } state_e;

   // Each pixel spends two beats per ODS word: one load/compute, one drive.
   function automatic int cc_beats(input int ods_words);
      return 2 * ods_words;
   endfunction

   function automatic int idx_width(input int n);
      return (n <= 2) ? 1 : $clog2(n);
   endfunction

endpackage

`default_nettype wire

// File: rtl/beat_counter.sv
// ============================================================================
// beat_counter - wrap counter with runtime limit, clear priority over increment
// Rev 1.0 - initial release
// ============================================================================
`default_nettype none

module beat_counter #(
   parameter int WIDTH = 4
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             inc_i,
   input  logic             clr_i,
   input  logic [WIDTH-1:0] limit_i,
   output logic [WIDTH-1:0] count_o,
   output logic             last_o
);

   logic [WIDTH-1:0] count_q;
   logic [WIDTH-1:0] count_d;

   assign count_o = count_q;
   assign last_o  = (count_q == limit_i);

   always_comb begin
      count_d = count_q;
      if (clr_i)
         count_d = '0;
      else if (inc_i)
         count_d = last_o ? '0 : count_q + WIDTH'(1);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         count_q <= '0;
      else
         count_q <= count_d;
   end

endmodule

`default_nettype wire

// File: rtl/conv_sched_fsm.sv
// ============================================================================
// conv_sched_fsm - kernel/row load and per-pixel compute/drain scheduler
// Rev 1.0 - initial release
// ============================================================================
`default_nettype none

module conv_sched_fsm
   import conv_sched_pkg::*;
#(
   parameter int FEATURE_MAP_WIDTH  = 1024,
   parameter int FEATURE_MAP_HEIGHT = 1024,
   parameter int OUTPUT_NB_CHANNELS = 64,
   parameter int CH_OUT_PAR         = 6,
   parameter int K_BEATS            = 12,
   parameter int K_GROUPS           = 6,
   parameter int I_BEATS            = 4,
   parameter int I_ROWS             = 3,
   parameter int ODS_WORDS          = 3
) (
   input  logic                               clk,
   input  logic                               arst_n_in,
   input  logic                               start,
   input  logic                               abort,
   output logic                               running,
   output logic                               done,
   input  logic                               con_valid,
   output logic                               con_ready,
   output logic                               output_valid,
   input  logic                               output_ready,
   output logic [31:0]                        output_x,
   output logic [31:0]                        output_y,
   output logic [31:0]                        output_ch,
   output logic [K_BEATS-1:0]                 ctrl_KDS_LE_select,
   output logic [idx_width(I_BEATS)-1:0]      ctrl_IDSS_LE_select,
   output logic                               ctrl_IDSS_shift,
   output logic [1:0]                         ctrl_ODS_sel_out,
   output logic                               ctrl_ODS_shift,
   output logic                               driving_cons
);

   localparam int CC_BEATS = cc_beats(ODS_WORDS);
   localparam int IW       = idx_width(I_BEATS);
   localparam int BMAX     = (K_BEATS > CC_BEATS) ? K_BEATS : CC_BEATS;
   localparam int BW       = idx_width(BMAX);
   localparam int KW       = idx_width(K_GROUPS);
   localparam int RW       = idx_width(I_ROWS);

   localparam logic [BW-1:0] K_LAST   = BW'(K_BEATS - 1);
   localparam logic [BW-1:0] I_LAST   = BW'(I_BEATS - 1);
   localparam logic [BW-1:0] CC_LAST  = BW'(CC_BEATS - 1);
   localparam logic [BW-1:0] ODS_N    = BW'(ODS_WORDS);
   localparam logic [BW-1:0] ODS_LAST = BW'(ODS_WORDS - 1);
   localparam logic [KW-1:0] KG_LAST  = KW'(K_GROUPS - 1);
   localparam logic [RW-1:0] IR_LAST  = RW'(I_ROWS - 1);
   localparam logic [31:0]   X_LAST   = 32'(FEATURE_MAP_WIDTH - 1);
   localparam logic [31:0]   Y_LAST   = 32'(FEATURE_MAP_HEIGHT - 1);
   localparam logic [31:0]   CH_STEP  = 32'(CH_OUT_PAR);
   localparam logic [31:0]   NB_CH    = 32'(OUTPUT_NB_CHANNELS);

   state_e        state_q, state_d;
   logic [31:0]   x_q, x_d, y_q, y_d, ch_q, ch_d;
   logic          ov_q, ov_d;
   logic [31:0]   ox_q, oy_q, och_q;
   logic          done_q, done_d;

   logic [BW-1:0] beat_q, beat_lim, ods_idx;
   logic          beat_inc, beat_clr, beat_last;
   logic [KW-1:0] kgrp_cnt;
   logic          kgrp_inc, kgrp_last;
   logic [RW-1:0] irow_cnt;
   logic          irow_inc, irow_last;
   logic          cnt_clr, consuming, adv, pix_done;
   logic          last_x, last_y, last_ch;
   logic          unused_cnt;

   assign unused_cnt = ^{kgrp_cnt, irow_cnt};

   beat_counter #(.WIDTH(BW)) u_beat (
      .clk(clk), .rst_n(arst_n_in), .inc_i(beat_inc), .clr_i(beat_clr),
      .limit_i(beat_lim), .count_o(beat_q), .last_o(beat_last)
   );

   beat_counter #(.WIDTH(KW)) u_kgrp (
      .clk(clk), .rst_n(arst_n_in), .inc_i(kgrp_inc), .clr_i(cnt_clr),
      .limit_i(KG_LAST), .count_o(kgrp_cnt), .last_o(kgrp_last)
   );

   beat_counter #(.WIDTH(RW)) u_irow (
      .clk(clk), .rst_n(arst_n_in), .inc_i(irow_inc), .clr_i(cnt_clr),
      .limit_i(IR_LAST), .count_o(irow_cnt), .last_o(irow_last)
   );

   assign last_x  = (x_q == X_LAST);
   assign last_y  = (y_q == Y_LAST);
   assign last_ch = ((ch_q + CH_STEP) >= NB_CH);
   assign ods_idx = (beat_q < ODS_N) ? beat_q : beat_q - ODS_N;

   always_comb begin
      case (state_q)
         ST_LOAD_K: beat_lim = K_LAST;
         ST_LOAD_I: beat_lim = I_LAST;
         default:   beat_lim = CC_LAST;
      endcase
   end

   always_comb begin
      state_d             = state_q;
      x_d                 = x_q;
      y_d                 = y_q;
      ch_d                = ch_q;
      done_d              = 1'b0;
      beat_inc            = 1'b0;
      beat_clr            = 1'b0;
      kgrp_inc            = 1'b0;
      irow_inc            = 1'b0;
      cnt_clr             = 1'b0;
      consuming           = 1'b0;
      adv                 = 1'b0;
      pix_done            = 1'b0;
      con_ready           = 1'b0;
      ctrl_KDS_LE_select  = '0;
      ctrl_IDSS_LE_select = '0;
      ctrl_IDSS_shift     = 1'b0;
      ctrl_ODS_sel_out    = 2'b11;
      ctrl_ODS_shift      = 1'b0;
      driving_cons        = 1'b0;

      case (state_q)
         ST_IDLE: begin
            beat_clr = 1'b1;
            cnt_clr  = 1'b1;
            x_d      = '0;
            y_d      = '0;
            ch_d     = '0;
            if (start)
               state_d = ST_LOAD_K;
         end
         ST_LOAD_K: begin
            con_ready          = 1'b1;
            ctrl_KDS_LE_select = K_BEATS'(1) << beat_q;
            if (con_valid) begin
               beat_inc = 1'b1;
               if (beat_last) begin
                  kgrp_inc = 1'b1;
                  if (kgrp_last)
                     state_d = ST_LOAD_I;
               end
            end
         end
         ST_LOAD_I: begin
            con_ready           = 1'b1;
            ctrl_IDSS_LE_select = beat_q[IW-1:0];
            if (con_valid) begin
               beat_inc = 1'b1;
               if (beat_last)
                  state_d = ST_I_SHIFT;
            end
         end
         ST_I_SHIFT: begin
            ctrl_IDSS_shift = 1'b1;
            irow_inc        = 1'b1;
            state_d         = irow_last ? ST_COMPUTE : ST_LOAD_I;
         end
         ST_COMPUTE: begin
            consuming        = (beat_q <= I_LAST);
            con_ready        = consuming;
            if (consuming)
               ctrl_IDSS_LE_select = beat_q[IW-1:0];
            ctrl_ODS_sel_out = 2'(ods_idx);
            driving_cons     = (beat_q >= ODS_N);
            ctrl_IDSS_shift  = (beat_q == ODS_LAST) || beat_last;
            ctrl_ODS_shift   = beat_last;
            // The final beat may not overwrite a result the sink has not taken.
            adv      = (!consuming || con_valid) && (!beat_last || !ov_q || output_ready);
            beat_inc = adv;
            pix_done = adv && beat_last;
            if (pix_done) begin
               if (!last_x) begin
                  x_d = x_q + 32'd1;
               end else if (!last_y) begin
                  x_d     = '0;
                  y_d     = y_q + 32'd1;
                  state_d = ST_LOAD_I;
               end else if (!last_ch) begin
                  x_d     = '0;
                  y_d     = '0;
                  ch_d    = ch_q + CH_STEP;
                  state_d = ST_LOAD_K;
               end else begin
                  state_d = ST_IDLE;
                  done_d  = 1'b1;
               end
            end
         end
         default: state_d = ST_IDLE;
      endcase

      if (abort) begin
         state_d  = ST_IDLE;
         beat_clr = 1'b1;
         cnt_clr  = 1'b1;
         x_d      = '0;
         y_d      = '0;
         ch_d     = '0;
         done_d   = 1'b0;
         pix_done = 1'b0;
      end

      ov_d = ov_q;
      if (ov_q && output_ready)
         ov_d = 1'b0;
      if (pix_done)
         ov_d = 1'b1;
      if (abort)
         ov_d = 1'b0;
   end

   always_ff @(posedge clk or negedge arst_n_in) begin
      if (!arst_n_in) begin
         state_q <= ST_IDLE;
         x_q     <= '0;
         y_q     <= '0;
         ch_q    <= '0;
         ov_q    <= 1'b0;
         ox_q    <= '0;
         oy_q    <= '0;
         och_q   <= '0;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         x_q     <= x_d;
         y_q     <= y_d;
         ch_q    <= ch_d;
         ov_q    <= ov_d;
         done_q  <= done_d;
         if (pix_done) begin
            ox_q  <= x_q;
            oy_q  <= y_q;
            och_q <= ch_q;
         end
      end
   end

   assign running      = (state_q != ST_IDLE);
   assign done         = done_q;
   assign output_valid = ov_q;
   assign output_x     = ox_q;
   assign output_y     = oy_q;
   assign output_ch    = och_q;

endmodule

`default_nettype wire

// File: doc/conv_sched_fsm.md
# conv_sched_fsm

Parametrised scheduler for the convolution datapath. It sequences kernel loads into the KDS, input-row loads into the IDSS, and per-pixel compute and drain through the ODS over a feature map processed in output-channel passes. It sits between the external handshake port and the datapath control pins. Compared with the fixed six-state-per-pixel generation, it adds:
- a per-beat `con_valid` handshake (stall on any beat);
- `output_ready` backpressure;
- a synchronous abort;
- a `done` pulse;
- fully parametrised beat, row and group counts.

## Interface
- FEATURE_MAP_WIDTH, 1024, pixels per row (≥1)
- FEATURE_MAP_HEIGHT, 1024, rows (≥1)
- OUTPUT_NB_CHANNELS, 64, total output channels
- CH_OUT_PAR, 6, output channels computed per pass
- K_BEATS, 12, KDS words per kernel group load (one-hot LE width)
- K_GROUPS, 6, kernel group loads per pass
- I_BEATS, 4, IDSS words per input row (≥2)
- I_ROWS, 3, rows preloaded at the start of each output row
- ODS_WORDS, 3, ODS words drained per pixel; CC_BEATS = 2*ODS_WORDS, with CC_BEATS ≥ I_BEATS
- clk  in  1  clock, all state updates on its rising edge
- arst_n_in  in  1  asynchronous reset, active low
- start  in  1  begin a job; sampled only in IDLE
- abort  in  1  synchronous abort, forces IDLE next cycle
- running  out  1  high in every state except IDLE
- done  out  1  one-cycle pulse when a job completes normally
- con_valid  in  1  external data valid
- con_ready  out  1  block accepts a data beat this cycle
- output_valid  out  1  registered; a pixel result is pending
- output_ready  in  1  sink accepts the pending result
- output_x / output_y / output_ch  out  32 each  coordinates of the pending result; output_ch is the base channel of the pass
- ctrl_KDS_LE_select  out  K_BEATS  one-hot KDS load enable
- ctrl_IDSS_LE_select  out  max(1,$clog2(I_BEATS))  IDSS word index
- ctrl_IDSS_shift  out  1  IDSS row shift
- ctrl_ODS_sel_out  out  2  ODS word select; 2'b11 means none
- ctrl_ODS_shift  out  1  ODS shift
- driving_cons  out  1  datapath drives the consumer bus

## Operation
- **States:** IDLE, LOAD_K, LOAD_I, I_SHIFT, COMPUTE.
- **Counters:**
  - x, y, ch (ch steps by CH_OUT_PAR);
  - beat, kgrp, irow.
- **Beat advance:**
  - A consuming beat advances only when con_valid && con_ready.
  - A non-consuming beat advances unconditionally, subject to the output rule below.
- **IDLE:** start=1 → LOAD_K. All counters clear.
- **LOAD_K:**
  - con_ready=1; ctrl_KDS_LE_select = 1<<beat.
  - After beat K_BEATS-1 is accepted, kgrp increments.
  - When kgrp = K_GROUPS-1 → LOAD_I; otherwise stay in LOAD_K with beat = 0.
- **LOAD_I:**
  - con_ready=1; ctrl_IDSS_LE_select = beat.
  - After beat I_BEATS-1 is accepted → I_SHIFT.
- **I_SHIFT:**
  - One cycle with ctrl_IDSS_shift=1; con_ready=0.
  - When irow = I_ROWS-1 → COMPUTE; otherwise irow increments and → LOAD_I.
- **COMPUTE, per beat p in 0..CC_BEATS-1:**
  - con_ready = (p < I_BEATS); ctrl_IDSS_LE_select = p while p < I_BEATS.
  - ctrl_ODS_sel_out = p mod ODS_WORDS.
  - driving_cons = (p ≥ ODS_WORDS).
  - ctrl_IDSS_shift=1 at p = ODS_WORDS-1 and at p = CC_BEATS-1.
  - ctrl_ODS_shift=1 at p = CC_BEATS-1.
- **Final beat (p = CC_BEATS-1):**
  - Completes only if !output_valid || output_ready; otherwise it holds with all outputs stable.
  - On completion, capture x, y, ch into the output registers and set output_valid.
  - Next state: !last_x → COMPUTE (x+1); else !last_y → LOAD_I (x=0, y+1); else !last_ch → LOAD_K (x=y=0, ch += CH_OUT_PAR); else → IDLE with done=1.
- **Termination and clearing:**
  - last_ch = ch + CH_OUT_PAR ≥ OUTPUT_NB_CHANNELS.
  - output_valid clears on output_valid && output_ready unless it is set again the same cycle. Set wins over clear.
- **Abort:** in any state, goes to IDLE and clears output_valid, beat, kgrp, irow, x, y, ch. No done pulse.
- **Defaults outside the listed conditions:** all ctrl outputs 0, except ctrl_ODS_sel_out = 2'b11.

## Timing
- **Reset values:** IDLE; running, done, con_ready, output_valid = 0; output_x/y/ch = 0; ctrl outputs at their defaults.
- **Output path:** con_ready and ctrl_* are combinational from state and counters. output_valid, output_x/y/ch and done are registered.
- **Stall-free latencies:**
  - Kernel load: K_BEATS*K_GROUPS cycles.
  - Row preload: I_ROWS*(I_BEATS+1) cycles.
  - Pixel: CC_BEATS cycles.
  - output_valid rises the cycle after the final compute beat.
- **Stalls and races:**
  - A con_valid low on any consuming beat freezes beat and outputs; it never skips a beat.
  - start asserted while running is ignored.
  - abort together with start in IDLE: abort wins.
  - An asynchronous reset mid-job returns to the reset values immediately.

## Structure
- Package conv_sched_pkg holds the state enum and the CC_BEATS and index-width helper functions.
- Sub-module beat_counter: a parametrised wrap counter with inc, clr and last outputs, instantiated for beat, kgrp and irow.

## Test plan
All scenarios use W=2, H=2, OUTPUT_NB_CHANNELS=12, CH_OUT_PAR=6, defaults otherwise.
- **Free run:** con_valid=1, output_ready=1, start pulse → done exactly 252 cycles after the first LOAD_K cycle. 8 results appear in order (x,y,ch) = (0,0,0),(1,0,0),(0,1,0),…,(1,1,6).
- **Handshake stall:** con_valid low for 5 cycles at LOAD_K beat 7 → ctrl_KDS_LE_select holds 12'h080 throughout; total run extends by exactly 5 cycles.
- **Backpressure:** output_ready=0 after the first result → FSM holds at pixel (1,0) beat 5 with ctrl_ODS_shift=1. output_x stays 0 until output_ready rises; the next result (1,0,0) follows one cycle later.
- **Abort:** abort during LOAD_I row 1 → IDLE next cycle, running=0, output_valid=0, no done. A new start then reproduces the free-run sequence.
- **Reset:** arst_n_in low mid-COMPUTE → all outputs at reset values asynchronously; ctrl_ODS_sel_out = 2'b11.
- **Start ignored:** start pulsed while running → sequence and cycle count unchanged from free run.
